// File: rtl/w_block_loader_pkg.sv
//------------------------------------------------------------------------------
// Module  : w_block_loader_pkg
// Purpose : Shared constants, state encoding and helpers for the W-stage
//           block loader and related pipeline feeders.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package w_block_loader_pkg;

  // Width of the packed W array and the W stage acceptance interval.
  localparam int WARR_S   = 512;
  localparam int DELAY    = 64;

  // Message word geometry; W_WORD_W * W_WORDS == WARR_S.
  localparam int W_WORD_W = 32;
  localparam int W_WORDS  = 16;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } ld_state_e;

  // Counter width able to hold GAP-1 (never narrower than one bit).
  function automatic int cnt_width(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/w_gap_timer.sv
//------------------------------------------------------------------------------
// Module  : w_gap_timer
// Purpose : Down-counter enforcing a minimum spacing between issue strobes.
//           A load reloads GAP-1; the count decrements to zero and holds.
// Ports   : clk         in  clock
//           rst_ni      in  asynchronous active-low reset
//           load_i      in  reload the counter with GAP-1
//           zero_o      out counter is zero this cycle
//           zero_next_o out counter will be zero next cycle
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module w_gap_timer
  import w_block_loader_pkg::*;
#(
  parameter int GAP = DELAY
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic load_i,
  output logic zero_o,
  output logic zero_next_o
);

  localparam int              CNT_W  = cnt_width(GAP);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(GAP - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o      = (cnt_q == '0);
  // Lets the owner register its issue strobe one cycle ahead.
  assign zero_next_o = (cnt_d == '0);

endmodule

`default_nettype wire

// File: rtl/w_block_loader.sv
//------------------------------------------------------------------------------
// Module  : w_block_loader
// Purpose : Packs 16 streamed 32-bit message words into one W array and
//           issues it to the W stage with a one-cycle en strobe, spacing
//           issues at least GAP cycles apart. Words keep arriving into a
//           shadow register while the previous W array is held.
// Config  : `define W_BLOCK_LOADER_BSWAP_EN to byte-reverse each word before
//           packing (little-endian host header words). Timing is unchanged.
// Ports   : clk      in  clock, rising edge
//           reset    in  asynchronous active-low reset
//           s_data   in  message word
//           s_valid  in  s_data valid
//           s_last   in  final word of block (qualified by transfer)
//           s_ready  out word accepted this cycle
//           W        out packed block, word 0 in the top bits
//           en       out one-cycle issue strobe
//           err      out one-cycle framing-error pulse
//           blk_cnt  out issued-block counter (wraps)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module w_block_loader
  import w_block_loader_pkg::*;
#(
  parameter int WORD_W = W_WORD_W,
  parameter int WORDS  = W_WORDS,
  parameter int GAP    = DELAY
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WORD_W-1:0]        s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [WORD_W*WORDS-1:0]  W,
  output logic                     en,
  output logic                     err,
  output logic [15:0]              blk_cnt
);

  localparam int               ARR_W    = WORD_W * WORDS;
  localparam int               IDX_W    = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  ld_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ARR_W-1:0]   shadow_q, shadow_d;
  logic [ARR_W-1:0]   warr_q;
  logic               ready_q, ready_d;
  logic               en_q, en_d;
  logic               err_q, err_d;
  logic [15:0]        blk_q;
  logic [WORD_W-1:0]  word_in;
  logic               xfer;
  logic               gap_zero;
  logic               gap_zero_next;
  logic               gap_load;

`ifdef W_BLOCK_LOADER_BSWAP_EN
  for (genvar b = 0; b < WORD_W / 8; b++) begin : g_bswap
    assign word_in[8*b +: 8] = s_data[WORD_W-8-8*b +: 8];
  end
`else
  assign word_in = s_data;
`endif

  // The issue happens in the cycle where FULL meets an expired gap; that
  // same condition reloads the timer.
  assign gap_load = (state_q == ST_FULL) && gap_zero;

  w_gap_timer #(
    .GAP (GAP)
  ) u_gap_timer (
    .clk         (clk),
    .rst_ni      (reset),
    .load_i      (gap_load),
    .zero_o      (gap_zero),
    .zero_next_o (gap_zero_next)
  );

  assign xfer = s_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            for (int k = 0; k < WORDS; k++) begin
              if (idx_q == IDX_W'(k)) shadow_d[ARR_W-1-WORD_W*k -: WORD_W] = word_in;
            end
            state_d = ST_FULL;
          end else if (s_last) begin
            // Short block: discard what was gathered and restart.
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            for (int k = 0; k < WORDS; k++) begin
              if (idx_q == IDX_W'(k)) shadow_d[ARR_W-1-WORD_W*k -: WORD_W] = word_in;
            end
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (gap_zero) begin
          state_d = ST_FILL;
          idx_d   = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase

    // Registered look-ahead: en is high exactly in the FULL cycle whose gap
    // count is zero, i.e. the cycle right after the 16th word when idle.
    en_d    = (state_d == ST_FULL) && gap_zero_next;
    ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FILL;
      idx_q    <= '0;
      shadow_q <= '0;
      warr_q   <= '0;
      ready_q  <= 1'b0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      blk_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      err_q    <= err_d;
      if (en_d) begin
        warr_q <= shadow_d;
        blk_q  <= blk_q + 1'b1;
      end
    end
  end

  assign s_ready = ready_q;
  assign W       = warr_q;
  assign en      = en_q;
  assign err     = err_q;
  assign blk_cnt = blk_q;

endmodule

`default_nettype wire

// File: tb/tb_w_block_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_w_block_loader
// Purpose : Scoreboard bench for w_block_loader. Stimulus pushes expected
//           issues/errors; a negedge monitor pops and compares them.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_w_block_loader;
  import w_block_loader_pkg::*;

  localparam int GAP = DELAY;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic [31:0]  s_data  = '0;
  logic         s_valid = 1'b0;
  logic         s_last  = 1'b0;
  logic         s_ready;
  logic [511:0] W;
  logic         en;
  logic         err;
  logic [15:0]  blk_cnt;

  w_block_loader #(
    .WORD_W (32),
    .WORDS  (16),
    .GAP    (GAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .W       (W),
    .en      (en),
    .err     (err),
    .blk_cnt (blk_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [511:0] w;
    logic [15:0]  blk;
    int           cyc;
  } en_exp_t;

  en_exp_t      en_sb[$];
  int           err_sb[$];
  logic [31:0]  blk_words[16];
  logic [15:0]  blk_exp = '0;
  int           last_en = -1000;
  logic [511:0] last_w  = '0;

  function automatic logic [31:0] pack_word(input logic [31:0] d);
`ifdef W_BLOCK_LOADER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every en / err must match the head of its scoreboard queue.
  always @(negedge clk) begin : mon
    en_exp_t e;
    int      ec;
    if (en === 1'b1) begin
      if (en_sb.size() == 0) begin
        check("unexpected_en", 1'b1, 1'b0);
      end else begin
        e = en_sb.pop_front();
        check("en_W", W, e.w);
        check("en_blk_cnt", 512'(blk_cnt), 512'(e.blk));
        check("en_cycle", 512'(cyc), 512'(e.cyc));
      end
    end
    if (err === 1'b1) begin
      if (err_sb.size() == 0) begin
        check("unexpected_err", 1'b1, 1'b0);
      end else begin
        ec = err_sb.pop_front();
        check("err_cycle", 512'(cyc), 512'(ec));
      end
    end
    if (en === 1'b1 && err === 1'b1) check("en_err_overlap", 1'b1, 1'b0);
  end

  task automatic fill_words(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < 16; k++) blk_words[k] = base + 32'(k) * step;
  endtask

  // Entered and left at posedge+1; returns the cycle the word transferred in.
  task automatic send_word(input logic [31:0] d, input logic last, output int xc);
    int n;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
    end
    if (n == 200) check("s_ready_timeout", 512'(s_ready), 512'(1));
    xc = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_block(input int last_at, input bit bubble);
    int           xc;
    int           en_cyc;
    logic [511:0] ew;
    xc = 0;
    for (int k = 0; k <= last_at; k++) begin
      send_word(blk_words[k], (k == last_at), xc);
      if (bubble) begin
        @(posedge clk);
        #1;
      end
    end
    if (last_at < 15) begin
      err_sb.push_back(xc + 1);
    end else begin
      ew = '0;
      for (int k = 0; k < 16; k++) ew[511-32*k -: 32] = pack_word(blk_words[k]);
      blk_exp = blk_exp + 16'd1;
      en_cyc  = (xc + 1 > last_en + GAP) ? xc + 1 : last_en + GAP;
      last_en = en_cyc;
      en_sb.push_back('{ew, blk_exp, en_cyc});
      last_w  = ew;
    end
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (en_sb.size() == 0 && err_sb.size() == 0) break;
    end
    if (n == 400) check("drain_timeout", 512'(en_sb.size() + err_sb.size()), 512'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [511:0] w_first;
    int           xc;

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 512'(s_ready), 512'(0));
    check("rst_en",      512'(en),      512'(0));
    check("rst_err",     512'(err),     512'(0));
    check("rst_blk_cnt", 512'(blk_cnt), 512'(0));
    check("rst_W",       W,             512'(0));
    reset = 1'b1;
    #1 check("s_ready_first_cycle", 512'(s_ready), 512'(0));
    @(posedge clk);
    #1;

    // Single block 0..15.
    fill_words(32'h0000_0000, 32'h1);
    send_block(15, 1'b0);

    // Framing error on word 5, then a normal block.
    fill_words(32'h0000_00A0, 32'h1);
    send_block(5, 1'b0);
    fill_words(32'h0000_0100, 32'h1);
    send_block(15, 1'b0);

    // Two back-to-back blocks: second issue is held off by the gap.
    fill_words(32'hB000_0000, 32'h3);
    send_block(15, 1'b0);
    w_first = last_w;
    fill_words(32'hC000_0000, 32'h5);
    send_block(15, 1'b0);
    @(negedge clk);
    check("full_wait_s_ready", 512'(s_ready), 512'(0));
    check("full_wait_W_hold",  W,             w_first);
    @(posedge clk);
    #1;

    // Bubbles between every word.
    fill_words(32'hD0D0_0000, 32'h0001_0001);
    send_block(15, 1'b1);

    // Async reset after word 9.
    wait_drain();
    fill_words(32'hE000_0000, 32'h1);
    for (int k = 0; k < 10; k++) send_word(blk_words[k], 1'b0, xc);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_s_ready", 512'(s_ready), 512'(0));
    check("mid_rst_en",      512'(en),      512'(0));
    check("mid_rst_err",     512'(err),     512'(0));
    check("mid_rst_blk_cnt", 512'(blk_cnt), 512'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    blk_exp = '0;
    last_en = -1000;
    #1 check("rel_s_ready", 512'(s_ready), 512'(0));
    @(posedge clk);
    #1;
    fill_words(32'hF000_0000, 32'h7);
    send_block(15, 1'b0);

    // Byte-order visibility: word 0 = 0x01020304.
    fill_words(32'h0102_0304, 32'h1111_1111);
    send_block(15, 1'b0);

    wait_drain();
    check("en_sb_empty",  512'(en_sb.size()),  512'(0));
    check("err_sb_empty", 512'(err_sb.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
